// File: rtl/box_scan_pkg.sv
// Shared definitions for the bounding-box raster-scan sequencer.
package box_scan_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CHECK = 2'd1,
      SCAN  = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int DEF_IMAGE_WIDTH  = 1280;
   localparam int DEF_IMAGE_HEIGHT = 720;
   localparam int COORD_W          = 12;

endpackage

// File: rtl/box_raster_counter.sv
// Raster position counter: walks x/y across the loaded box, keeps the running
// row base address so no per-beat multiply is needed, and flags the final beat.
module box_raster_counter
   import box_scan_pkg::*;
#(
   parameter int ADDR_W = 20
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load_i,
   input  logic               advance_i,
   input  logic [COORD_W-1:0] x1_i,
   input  logic [COORD_W-1:0] y1_i,
   input  logic [COORD_W-1:0] x2_i,
   input  logic [COORD_W-1:0] y2_i,
   input  logic [3:0]         step_i,
   input  logic [ADDR_W-1:0]  row_base_i,
   input  logic [ADDR_W-1:0]  row_step_i,
   output logic [COORD_W-1:0] x_o,
   output logic [COORD_W-1:0] y_o,
   output logic [ADDR_W-1:0]  addr_o,
   output logic               last_o
);

   logic [COORD_W-1:0] x, y, x1_r, x2_r, y2_r;
   logic [3:0]         step_r;
   logic [ADDR_W-1:0]  row_base, row_step;
   logic [COORD_W:0]   x_sum, y_sum;
   logic               row_end, col_end;

   // Next-position sums carry one extra bit so the end tests cannot wrap.
   always_comb begin
      x_sum   = {1'b0, x} + {{(COORD_W-3){1'b0}}, step_r};
      y_sum   = {1'b0, y} + {{(COORD_W-3){1'b0}}, step_r};
      row_end = (x_sum > {1'b0, x2_r});
      col_end = (y_sum > {1'b0, y2_r});
      last_o  = row_end && col_end;
      addr_o  = row_base + ADDR_W'(x);
      x_o     = x;
      y_o     = y;
   end

   // Load the box on entry to the scan, then step one position per accepted beat.
   always_ff @(posedge clk) begin
      if (rst) begin
         x        <= '0;
         y        <= '0;
         x1_r     <= '0;
         x2_r     <= '0;
         y2_r     <= '0;
         step_r   <= 4'd1;
         row_base <= '0;
         row_step <= '0;
      end else if (load_i) begin
         x        <= x1_i;
         y        <= y1_i;
         x1_r     <= x1_i;
         x2_r     <= x2_i;
         y2_r     <= y2_i;
         step_r   <= step_i;
         row_base <= row_base_i;
         row_step <= row_step_i;
      end else if (advance_i) begin
         if (!row_end) begin
            x <= x_sum[COORD_W-1:0];
         end else begin
            x        <= x1_r;
            y        <= y_sum[COORD_W-1:0];
            row_base <= row_base + row_step;
         end
      end
   end

endmodule

// File: rtl/box_scan_sequencer.sv
// Bounding-box raster-scan sequencer: snapshots the box corners on start,
// clamps and validates them, then streams every pixel address in the box.
// Optional feature macro: BOX_SCAN_STRIDE_EN adds stride_i for sub-sampled scans.
module box_scan_sequencer
   import box_scan_pkg::*;
#(
   parameter int IMAGE_WIDTH  = DEF_IMAGE_WIDTH,
   parameter int IMAGE_HEIGHT = DEF_IMAGE_HEIGHT,
   parameter int ADDR_W       = 20
) (
   input  logic               clk,
   input  logic               rst,
`ifdef BOX_SCAN_STRIDE_EN
   input  logic [3:0]         stride_i,
`endif
   input  logic               start_i,
   input  logic               abort_i,
   input  logic [15:0]        x1_i,
   input  logic [15:0]        x2_i,
   input  logic [15:0]        y1_i,
   input  logic [15:0]        y2_i,
   input  logic               ready_i,
   output logic               valid_o,
   output logic [ADDR_W-1:0]  addr_o,
   output logic [COORD_W-1:0] x_o,
   output logic [COORD_W-1:0] y_o,
   output logic               last_o,
   output logic               busy_o,
   output logic               done_o,
   output logic               err_o
);

   localparam logic [15:0]        X_MAX16 = 16'(IMAGE_WIDTH - 1);
   localparam logic [15:0]        Y_MAX16 = 16'(IMAGE_HEIGHT - 1);
   localparam logic [COORD_W-1:0] X_MAX12 = COORD_W'(IMAGE_WIDTH - 1);
   localparam logic [COORD_W-1:0] Y_MAX12 = COORD_W'(IMAGE_HEIGHT - 1);

   state_t             state, state_nxt;
   logic [15:0]        x1_s, y1_s, x2_s, y2_s;
   logic [3:0]         step_s;
   logic [COORD_W-1:0] x2_c, y2_c;
   logic               box_bad;
   logic               err_q;
   logic               load, advance, last_c;
   logic [ADDR_W-1:0]  row_base_init, row_step_c;

`ifdef BOX_SCAN_STRIDE_EN
   // Stride is snapshotted with the corners; zero is treated as a stride of one.
   always_ff @(posedge clk) begin
      if (rst)
         step_s <= 4'd1;
      else if (state == IDLE && start_i)
         step_s <= (stride_i == 4'd0) ? 4'd1 : stride_i;
   end
`else
   assign step_s = 4'd1;
`endif

   // Shadow copy of the corners so the box cannot change under a running scan.
   always_ff @(posedge clk) begin
      if (rst) begin
         x1_s <= '0;
         y1_s <= '0;
         x2_s <= '0;
         y2_s <= '0;
      end else if (state == IDLE && start_i) begin
         x1_s <= x1_i;
         y1_s <= y1_i;
         x2_s <= x2_i;
         y2_s <= y2_i;
      end
   end

   // Clamp the far corner to the frame and reject empty or off-frame boxes;
   // the only multiplies live here and are consumed in the CHECK cycle.
   always_comb begin
      x2_c          = (x2_s > X_MAX16) ? X_MAX12 : x2_s[COORD_W-1:0];
      y2_c          = (y2_s > Y_MAX16) ? Y_MAX12 : y2_s[COORD_W-1:0];
      box_bad       = (x1_s > {4'b0, x2_c}) || (y1_s > {4'b0, y2_c}) ||
                      (x1_s > X_MAX16) || (y1_s > Y_MAX16);
      row_base_init = ADDR_W'(y1_s[COORD_W-1:0]) * ADDR_W'(IMAGE_WIDTH);
      row_step_c    = ADDR_W'(step_s) * ADDR_W'(IMAGE_WIDTH);
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Next-state logic; abort overrides both the box check and the handshake.
   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      advance   = 1'b0;
      case (state)
         IDLE: begin
            if (start_i)
               state_nxt = CHECK;
         end
         CHECK: begin
            if (abort_i || box_bad) begin
               state_nxt = IDLE;
            end else begin
               load      = 1'b1;
               state_nxt = SCAN;
            end
         end
         SCAN: begin
            if (abort_i) begin
               state_nxt = IDLE;
            end else if (ready_i) begin
               advance = 1'b1;
               if (last_c)
                  state_nxt = DONE;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Rejection pulse appears the cycle after CHECK.
   always_ff @(posedge clk) begin
      if (rst)
         err_q <= 1'b0;
      else
         err_q <= (state == CHECK) && !abort_i && box_bad;
   end

   box_raster_counter #(
      .ADDR_W(ADDR_W)
   ) u_counter (
      .clk        (clk),
      .rst        (rst),
      .load_i     (load),
      .advance_i  (advance),
      .x1_i       (x1_s[COORD_W-1:0]),
      .y1_i       (y1_s[COORD_W-1:0]),
      .x2_i       (x2_c),
      .y2_i       (y2_c),
      .step_i     (step_s),
      .row_base_i (row_base_init),
      .row_step_i (row_step_c),
      .x_o        (x_o),
      .y_o        (y_o),
      .addr_o     (addr_o),
      .last_o     (last_c)
   );

   // Status and handshake outputs decoded from the state.
   always_comb begin
      valid_o = (state == SCAN);
      last_o  = (state == SCAN) && last_c;
      busy_o  = (state == CHECK) || (state == SCAN);
      done_o  = (state == DONE);
      err_o   = err_q;
   end

endmodule

// File: tb/tb_box_scan_sequencer.sv
// Directed self-checking bench for box_scan_sequencer.
module tb_box_scan_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  stride_i;
   logic        start_i, abort_i, ready_i;
   logic [15:0] x1_i, x2_i, y1_i, y2_i;
   logic        valid_o, last_o, busy_o, done_o, err_o;
   logic [19:0] addr_o;
   logic [11:0] x_o, y_o;

   int vectors     = 0;
   int miscompares = 0;

   box_scan_sequencer dut (
      .clk      (clk),
      .rst      (rst),
`ifdef BOX_SCAN_STRIDE_EN
      .stride_i (stride_i),
`endif
      .start_i  (start_i),
      .abort_i  (abort_i),
      .x1_i     (x1_i),
      .x2_i     (x2_i),
      .y1_i     (y1_i),
      .y2_i     (y2_i),
      .ready_i  (ready_i),
      .valid_o  (valid_o),
      .addr_o   (addr_o),
      .x_o      (x_o),
      .y_o      (y_o),
      .last_o   (last_o),
      .busy_o   (busy_o),
      .done_o   (done_o),
      .err_o    (err_o)
   );

   always #5 clk = ~clk;

   // Advance one clock and settle just past the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Launch a box with ready held high and collect beats until done or budget.
   task automatic run_scan(input logic [15:0] ax1, input logic [15:0] ay1,
                           input logic [15:0] ax2, input logic [15:0] ay2,
                           input logic [3:0] astride, input int budget,
                           output int beats, output logic [19:0] last_addr,
                           output int last_at, output bit done_seen);
      beats = 0; last_addr = '0; last_at = 0; done_seen = 1'b0;
      x1_i = ax1; y1_i = ay1; x2_i = ax2; y2_i = ay2;
      stride_i = astride; ready_i = 1'b1; start_i = 1'b1;
      tick();
      start_i = 1'b0;
      for (int c = 0; c < budget; c++) begin
         tick();
         if (done_o) begin
            done_seen = 1'b1;
            break;
         end
         if (valid_o && ready_i) begin
            beats++;
            if (last_o) begin
               last_addr = addr_o;
               last_at   = beats;
            end
         end
      end
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(); tick();
      vectors++; if (valid_o !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_valid got %b want 0", valid_o); end
      vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy got %b want 0", busy_o); end
      vectors++; if ({last_o, done_o, err_o} !== 3'b000) begin miscompares++; $display("[TB] FAIL reset_flags got %b want 000", {last_o, done_o, err_o}); end
      vectors++; if ({addr_o, x_o, y_o} !== 44'd0) begin miscompares++; $display("[TB] FAIL reset_coords got addr=%0d x=%0d y=%0d want 0", addr_o, x_o, y_o); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_basic_scan();
      logic [19:0] exp_addr [6];
      exp_addr = '{20'd0, 20'd1, 20'd2, 20'd1280, 20'd1281, 20'd1282};
      x1_i = 16'd0; y1_i = 16'd0; x2_i = 16'd2; y2_i = 16'd1;
      ready_i = 1'b1; start_i = 1'b1;
      tick();
      start_i = 1'b0;
      vectors++; if ({busy_o, valid_o} !== 2'b10) begin miscompares++; $display("[TB] FAIL basic_check_cycle got busy/valid=%b want 10", {busy_o, valid_o}); end
      for (int i = 0; i < 6; i++) begin
         tick();
         vectors++;
         if ({valid_o, addr_o, last_o} !== {1'b1, exp_addr[i], (i == 5)}) begin
            miscompares++;
            $display("[TB] FAIL basic_beat%0d got valid=%b addr=%0d last=%b want 1/%0d/%b",
                     i, valid_o, addr_o, last_o, exp_addr[i], (i == 5));
         end
      end
      tick();
      vectors++; if ({done_o, valid_o} !== 2'b10) begin miscompares++; $display("[TB] FAIL basic_done got done/valid=%b want 10", {done_o, valid_o}); end
      tick();
      vectors++; if ({done_o, busy_o} !== 2'b00) begin miscompares++; $display("[TB] FAIL basic_idle got done/busy=%b want 00", {done_o, busy_o}); end
   endtask

   task automatic test_backpressure();
      x1_i = 16'd10; y1_i = 16'd10; x2_i = 16'd11; y2_i = 16'd10;
      ready_i = 1'b0; start_i = 1'b1;
      tick();
      start_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         vectors++;
         if ({valid_o, addr_o, x_o, y_o, last_o} !== {1'b1, 20'd12810, 12'd10, 12'd10, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL stall_hold%0d got valid=%b addr=%0d x=%0d y=%0d last=%b want 1/12810/10/10/0",
                     i, valid_o, addr_o, x_o, y_o, last_o);
         end
      end
      ready_i = 1'b1;
      tick();
      vectors++; if ({valid_o, addr_o, last_o} !== {1'b1, 20'd12811, 1'b1}) begin miscompares++; $display("[TB] FAIL stall_second got valid=%b addr=%0d last=%b want 1/12811/1", valid_o, addr_o, last_o); end
      tick();
      vectors++; if (done_o !== 1'b1) begin miscompares++; $display("[TB] FAIL stall_done got %b want 1", done_o); end
      tick();
   endtask

   task automatic test_reject_and_clamp();
      int beats, last_at;
      logic [19:0] last_addr;
      bit done_seen;
      x1_i = 16'd50; y1_i = 16'd0; x2_i = 16'd40; y2_i = 16'd0;
      ready_i = 1'b1; start_i = 1'b1;
      tick();
      start_i = 1'b0;
      vectors++; if ({err_o, valid_o} !== 2'b00) begin miscompares++; $display("[TB] FAIL reject_check got err/valid=%b want 00", {err_o, valid_o}); end
      tick();
      vectors++; if ({err_o, valid_o, busy_o} !== 3'b100) begin miscompares++; $display("[TB] FAIL reject_pulse got err/valid/busy=%b want 100", {err_o, valid_o, busy_o}); end
      tick();
      vectors++; if ({err_o, valid_o} !== 2'b00) begin miscompares++; $display("[TB] FAIL reject_after got err/valid=%b want 00", {err_o, valid_o}); end
      // Off-frame top bits on x1 must also be rejected.
      x1_i = 16'h1005; x2_i = 16'h1006; start_i = 1'b1;
      tick(); start_i = 1'b0; tick();
      vectors++; if ({err_o, valid_o} !== 2'b10) begin miscompares++; $display("[TB] FAIL reject_highbits got err/valid=%b want 10", {err_o, valid_o}); end
      tick();
      run_scan(16'd1275, 16'd715, 16'd1400, 16'd800, 4'd1, 60, beats, last_addr, last_at, done_seen);
      vectors++; if (beats !== 25) begin miscompares++; $display("[TB] FAIL clamp_beats got %0d want 25", beats); end
      vectors++; if (last_addr !== 20'd921599) begin miscompares++; $display("[TB] FAIL clamp_last_addr got %0d want 921599", last_addr); end
      vectors++; if (last_at !== 25) begin miscompares++; $display("[TB] FAIL clamp_last_pos got %0d want 25", last_at); end
      vectors++; if (done_seen !== 1'b1) begin miscompares++; $display("[TB] FAIL clamp_done got %b want 1", done_seen); end
      run_scan(16'd7, 16'd3, 16'd7, 16'd3, 4'd1, 10, beats, last_addr, last_at, done_seen);
      vectors++; if ({beats, last_at, last_addr} !== {32'd1, 32'd1, 20'd3847}) begin miscompares++; $display("[TB] FAIL single_pixel got beats=%0d last_at=%0d addr=%0d want 1/1/3847", beats, last_at, last_addr); end
   endtask

   task automatic test_abort();
      x1_i = 16'd100; y1_i = 16'd200; x2_i = 16'd149; y2_i = 16'd249;
      ready_i = 1'b1; start_i = 1'b1;
      tick();
      start_i = 1'b0;
      tick(); tick(); tick();
      vectors++; if ({valid_o, x_o, y_o} !== {1'b1, 12'd102, 12'd200}) begin miscompares++; $display("[TB] FAIL abort_third_beat got valid=%b x=%0d y=%0d want 1/102/200", valid_o, x_o, y_o); end
      abort_i = 1'b1;
      tick();
      abort_i = 1'b0;
      vectors++; if ({valid_o, busy_o, done_o, err_o} !== 4'b0000) begin miscompares++; $display("[TB] FAIL abort_stop got valid/busy/done/err=%b want 0000", {valid_o, busy_o, done_o, err_o}); end
      tick();
      vectors++; if ({done_o, err_o} !== 2'b00) begin miscompares++; $display("[TB] FAIL abort_no_pulse got done/err=%b want 00", {done_o, err_o}); end
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      tick();
      vectors++; if ({valid_o, x_o, y_o, addr_o} !== {1'b1, 12'd100, 12'd200, 20'd256100}) begin miscompares++; $display("[TB] FAIL abort_restart got valid=%b x=%0d y=%0d addr=%0d want 1/100/200/256100", valid_o, x_o, y_o, addr_o); end
      abort_i = 1'b1;
      tick();
      abort_i = 1'b0;
      tick();
   endtask

   task automatic test_ignored_inputs();
      int beats;
      logic [19:0] last_addr;
      bit done_seen;
      beats = 0; last_addr = '0; done_seen = 1'b0;
      x1_i = 16'd0; y1_i = 16'd0; x2_i = 16'd3; y2_i = 16'd2;
      ready_i = 1'b1; start_i = 1'b1;
      tick();
      start_i = 1'b0;
      for (int c = 0; c < 40; c++) begin
         tick();
         start_i = (beats == 4);
         if (beats == 4) x1_i = 16'd2;
         if (done_o) begin
            done_seen = 1'b1;
            break;
         end
         if (valid_o) begin
            beats++;
            if (last_o) last_addr = addr_o;
         end
      end
      start_i = 1'b0;
      vectors++; if (beats !== 12) begin miscompares++; $display("[TB] FAIL ignore_beats got %0d want 12", beats); end
      vectors++; if ({done_seen, last_addr} !== {1'b1, 20'd2563}) begin miscompares++; $display("[TB] FAIL ignore_last got done=%b addr=%0d want 1/2563", done_seen, last_addr); end
      tick();
      vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("[TB] FAIL ignore_no_requeue got busy=%b want 0", busy_o); end
      // Reset in the middle of a scan.
      x1_i = 16'd5; y1_i = 16'd5; x2_i = 16'd20; y2_i = 16'd20; start_i = 1'b1;
      tick();
      start_i = 1'b0;
      tick(); tick(); tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      vectors++;
      if ({valid_o, busy_o, last_o, done_o, err_o, addr_o, x_o, y_o} !== 49'd0) begin
         miscompares++;
         $display("[TB] FAIL midscan_reset got valid=%b busy=%b addr=%0d x=%0d y=%0d want all 0",
                  valid_o, busy_o, addr_o, x_o, y_o);
      end
      tick();
   endtask

`ifdef BOX_SCAN_STRIDE_EN
   task automatic test_stride();
      int beats, last_at;
      logic [19:0] last_addr;
      bit done_seen;
      run_scan(16'd0, 16'd0, 16'd9, 16'd9, 4'd4, 40, beats, last_addr, last_at, done_seen);
      vectors++; if (beats !== 9) begin miscompares++; $display("[TB] FAIL stride_beats got %0d want 9", beats); end
      vectors++; if ({last_addr, last_at} !== {20'd10248, 32'd9}) begin miscompares++; $display("[TB] FAIL stride_last got addr=%0d pos=%0d want 10248/9", last_addr, last_at); end
      vectors++; if (done_seen !== 1'b1) begin miscompares++; $display("[TB] FAIL stride_done got %b want 1", done_seen); end
      stride_i = 4'd1;
   endtask
`endif

   initial begin
      rst = 1'b1; start_i = 1'b0; abort_i = 1'b0; ready_i = 1'b0;
      x1_i = '0; x2_i = '0; y1_i = '0; y2_i = '0; stride_i = 4'd1;
      test_reset();
      test_basic_scan();
      test_backpressure();
      test_reject_and_clamp();
      test_abort();
      test_ignored_inputs();
`ifdef BOX_SCAN_STRIDE_EN
      test_stride();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
